vec_scalar_transfer_unit: RTL

- Multi-cycle execution engine for scalar↔vector register moves in the RV32I + vector core.
- Sits directly downstream of the rerouting decoder and consumes its rerouting_select / rerouting_code.
- Moves data in both directions: scalar-to-vector (broadcast, lane insert) and vector-to-scalar (lane extract, lane reductions).
- Drives write ports toward the scalar and vector register files; the pipeline stalls on busy.

---
 rtl/vec_scalar_transfer_unit_if.sv | 36 +++
 rtl/vec_scalar_transfer_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/vec_scalar_transfer_unit_if.sv
// Request/result bundle between the issue stage and the scalar<->vector transfer engine.
// The issue side is the master; the engine is the slave.
interface vec_scalar_transfer_unit_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned XLEN  = 32
);
  localparam int unsigned LIDX = $clog2(LANES);

  logic                    start;
  logic                    rerouting_select;
  logic [2:0]              rerouting_code;
  logic [LIDX-1:0]         lane_idx;
  logic [XLEN-1:0]         scalar_in;
  logic [LANES*XLEN-1:0]   vector_in;

  logic                    busy;
  logic                    done;
  logic                    illegal;
  logic                    scalar_wr_en;
  logic [XLEN-1:0]         scalar_out;
  logic                    vector_wr_en;
  logic [LANES-1:0]        vector_lane_mask;
  logic [LANES*XLEN-1:0]   vector_out;

  modport master (
    output start, rerouting_select, rerouting_code, lane_idx, scalar_in, vector_in,
    input  busy, done, illegal, scalar_wr_en, scalar_out,
           vector_wr_en, vector_lane_mask, vector_out
  );

  modport slave (
    input  start, rerouting_select, rerouting_code, lane_idx, scalar_in, vector_in,
    output busy, done, illegal, scalar_wr_en, scalar_out,
           vector_wr_en, vector_lane_mask, vector_out
  );
endinterface

// File: rtl/vec_scalar_transfer_unit.sv
// Scalar<->vector move engine: broadcast, lane insert, lane extract and
// lane reductions (wrapping sum, signed max, signed min), one lane per cycle.
module vec_scalar_transfer_unit #(
  parameter int unsigned LANES = 4,
  parameter int unsigned XLEN  = 32
) (
  input logic                      clk,
  input logic                      rst,
  vec_scalar_transfer_unit_if.slave bus
);
  localparam int unsigned LIDX = $clog2(LANES);
  localparam int unsigned VW   = LANES * XLEN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDUCE,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_BCAST   = 3'b000,
    OP_INSERT  = 3'b001,
    OP_RSV2    = 3'b010,
    OP_RSV3    = 3'b011,
    OP_EXTRACT = 3'b100,
    OP_SUM     = 3'b101,
    OP_MAX     = 3'b110,
    OP_MIN     = 3'b111
  } op_e;

  state_e            r_state;
  state_e            w_next;

  op_e               r_code;
  logic [LIDX-1:0]   r_idx;
  logic [VW-1:0]     r_vec;
  logic [XLEN-1:0]   r_acc;
  logic [LIDX-1:0]   r_cnt;
  logic [XLEN-1:0]   r_scalar_out;
  logic [VW-1:0]     r_vector_out;

  op_e               w_in_code;
  logic              w_accept;
  logic              w_in_reduce;
  logic              w_last;
  logic              w_done;
  logic [XLEN-1:0]   w_extract;
  logic [XLEN-1:0]   w_cur_lane;
  logic [XLEN-1:0]   w_fold;
  logic [VW-1:0]     w_bcast_vec;
  logic [VW-1:0]     w_insert_vec;
  logic [LANES-1:0]  w_mask;

  function automatic logic [XLEN-1:0] fold(input op_e op,
                                           input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
    logic [XLEN-1:0] res;
    res = a;
    case (op)
      OP_SUM: res = a + b;
      OP_MAX: if ($signed(b) > $signed(a)) res = b;
      OP_MIN: if ($signed(b) < $signed(a)) res = b;
      default: res = a;
    endcase
    return res;
  endfunction

  assign w_in_code   = op_e'(bus.rerouting_code);
  assign w_accept    = (r_state == S_IDLE) && bus.start && bus.rerouting_select;
  assign w_in_reduce = (w_in_code == OP_SUM) || (w_in_code == OP_MAX) ||
                       (w_in_code == OP_MIN);
  assign w_last      = (r_cnt == LIDX'(LANES - 1));
  assign w_done      = (r_state == S_DONE);

  // Lane muxes over the incoming operand (extract/insert) and the held operand (fold).
  always_comb begin
    w_extract    = '0;
    w_cur_lane   = '0;
    w_bcast_vec  = '0;
    w_insert_vec = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_bcast_vec[i*XLEN +: XLEN] = bus.scalar_in;
      if (LIDX'(i) == bus.lane_idx) begin
        w_extract                    = bus.vector_in[i*XLEN +: XLEN];
        w_insert_vec[i*XLEN +: XLEN] = bus.scalar_in;
      end
      if (LIDX'(i) == r_cnt) begin
        w_cur_lane = r_vec[i*XLEN +: XLEN];
      end
    end
  end

  assign w_fold = fold(r_code, r_acc, w_cur_lane);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_in_reduce ? S_REDUCE : S_DONE;
        end
      end
      S_REDUCE: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Single-cycle results are computed from the live inputs at accept and land in
  // the output registers in time for DONE, so only the vector operand is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_code       <= OP_BCAST;
      r_idx        <= '0;
      r_vec        <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_scalar_out <= '0;
      r_vector_out <= '0;
    end else if (w_accept) begin
      r_code <= w_in_code;
      r_idx  <= bus.lane_idx;
      r_vec  <= bus.vector_in;
      r_acc  <= bus.vector_in[XLEN-1:0];
      r_cnt  <= LIDX'(1);
      case (w_in_code)
        OP_BCAST:   r_vector_out <= w_bcast_vec;
        OP_INSERT:  r_vector_out <= w_insert_vec;
        OP_EXTRACT: r_scalar_out <= w_extract;
        default:    ;
      endcase
    end else if (r_state == S_REDUCE) begin
      r_acc <= w_fold;
      r_cnt <= r_cnt + LIDX'(1);
      if (w_last) begin
        r_scalar_out <= w_fold;
      end
    end
  end

  always_comb begin
    w_mask = '0;
    if (w_done) begin
      case (r_code)
        OP_BCAST:  w_mask = '1;
        OP_INSERT: w_mask[r_idx] = 1'b1;
        default:   w_mask = '0;
      endcase
    end
  end

  assign bus.busy             = (r_state != S_IDLE);
  assign bus.done             = w_done;
  assign bus.illegal          = w_done && ((r_code == OP_RSV2) || (r_code == OP_RSV3));
  assign bus.scalar_wr_en     = w_done && ((r_code == OP_EXTRACT) || (r_code == OP_SUM) ||
                                           (r_code == OP_MAX) || (r_code == OP_MIN));
  assign bus.vector_wr_en     = w_done && ((r_code == OP_BCAST) || (r_code == OP_INSERT));
  assign bus.vector_lane_mask = w_mask;
  assign bus.scalar_out       = r_scalar_out;
  assign bus.vector_out       = r_vector_out;
endmodule
